gol_gen_scheduler: RTL
======================

# gol_gen_scheduler

Generation scheduler for the Game of Life datapath. It turns single-step requests (`get_next`) or continuous run mode into a row-by-row generation sweep. For each sweep it fetches rows from the current-state buffer into the engine's line buffers, starts the engine on each row, and swaps the ping-pong state buffers when the last row completes. A new generation starts only during display vertical blanking, so the frame being scanned never tears.

## Interface
Parameters:
- `WIDTH`, default 640: grid columns. Informational only; passed through to the engine.
- `HEIGHT`, default 480: grid rows. Must be at least 2.
- `ROW_AW`, default 9: row address width. Must satisfy 2^ROW_AW >= HEIGHT.

Ports:
- `clk`  in  1  single clock domain; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `run`  in  1  level; while high, generations repeat back-to-back, one per blanking window.
- `get_next`  in  1  single-cycle pulse; requests exactly one generation.
- `vblank`  in  1  level; high while the display is in vertical blanking.
- `rd_valid`  out  1  row-fetch request to the state buffer.
- `rd_row`  out  ROW_AW  row to fetch. Stable while `rd_valid` is high and `rd_ready` is low.
- `rd_ready`  in  1  fetch accepted; a transfer occurs when `rd_valid` and `rd_ready` are both high.
- `eng_start`  out  1  one-cycle pulse; engine computes row `eng_row`.
- `eng_row`  out  ROW_AW  row being computed. Held from `eng_start` until `eng_done`.
- `eng_first`  out  1  `eng_row == 0`; the engine treats the row above as dead.
- `eng_last`  out  1  `eng_row == HEIGHT-1`; the engine treats the row below as dead.
- `eng_done`  in  1  one-cycle pulse; engine finished the current row.
- `buf_swap`  out  1  one-cycle pulse; swap current/next state buffers.
- `busy`  out  1  high in every state except IDLE.
- `gen_count`  out  32  completed generations. Wraps modulo 2^32.

## Operation
- States: IDLE, WAIT_VB, FETCH, START, ENG_WAIT, SWAP.
- Internal registers: `fetch_row` (ROW_AW bits), `eng_row` (ROW_AW bits), `pending` (1 bit).
- `pending` behaviour:
  - Set by `get_next` in any state other than IDLE.
  - Only one request is stored; further pulses while `pending` is already set are dropped.
  - Cleared on the WAIT_VB→FETCH transition.
- IDLE → WAIT_VB when `run` or `get_next` is high.
- WAIT_VB → FETCH when `vblank` is high, with `fetch_row` = 0. `vblank` is sampled only in WAIT_VB; it does not matter during a sweep.
- FETCH behaviour:
  - `rd_valid` = 1 and `rd_row` = `fetch_row`.
  - On the handshake cycle, if `fetch_row` == 0, set `fetch_row` to 1 and stay in FETCH (priming the line buffers).
  - Otherwise set `eng_row` to `fetch_row`-1 and go to START.
- START: `eng_start` = 1 for exactly one cycle, then go to ENG_WAIT.
- ENG_WAIT, on `eng_done`:
  - If `eng_row` == HEIGHT-1, go to SWAP.
  - If `eng_row` == HEIGHT-2, set `eng_row` to HEIGHT-1 and go to START. No fetch occurs; the bottom halo is dead.
  - Otherwise set `fetch_row` to `eng_row`+2 and go to FETCH.
- SWAP:
  - `buf_swap` = 1 for one cycle and `gen_count` increments.
  - Next state is WAIT_VB if `run` or `pending` is high, otherwise IDLE.
- Row order per generation: fetch 0, 1, …, HEIGHT-1, each exactly once; compute 0, …, HEIGHT-1, each exactly once. Row r+1 is always fetched before row r is started.
- Ignored inputs:
  - `eng_done` outside ENG_WAIT.
  - `rd_ready` while `rd_valid` is low.
  - `run` deasserting mid-sweep; the current generation always completes.

## Timing
- Reset values:
  - State is IDLE.
  - All outputs are 0: `rd_valid`, `rd_row`, `eng_start`, `eng_row`, `eng_first`, `eng_last`, `buf_swap`, `busy`, `gen_count`.
  - `pending` = 0 and `fetch_row` = 0.
- Reset asserted mid-sweep aborts immediately, with no `buf_swap`. The first generation after release starts again from row 0.
- All outputs are registered or decoded from state and registers only; there is no combinational input→output path.
- Latency from `get_next` sampled in IDLE with `vblank` high: `busy` high at cycle +1, `rd_valid` high at cycle +2.
- Minimum sweep length with `rd_ready` tied high and `eng_done` arriving one cycle after `eng_start`: 3·HEIGHT+1 cycles from entering FETCH to the SWAP cycle inclusive.
- `eng_first` and `eng_last` are valid in the same cycle as `eng_start` and stay valid until `eng_done`.

## Test plan
- Single step, HEIGHT=4, `vblank`=1, `rd_ready`=1, `eng_done` one cycle after start:
  - Pulse `get_next` → fetch sequence 0,1,2,3 and compute sequence 0,1,2,3.
  - `eng_first` only with row 0; `eng_last` only with row 3.
  - One `buf_swap`, `gen_count`=1, back in IDLE with `busy`=0.
- Blanking gate: `vblank`=0 when `get_next` pulses → no `rd_valid` for 50 cycles. Raise `vblank` → `rd_valid` high 1 cycle after WAIT_VB samples it.
- Backpressure: hold `rd_ready`=0 for 7 cycles on row 2 → `rd_row`=2 stable throughout and no `eng_start` until the handshake.
- Pending collapse: three `get_next` pulses during a sweep → exactly 2 generations total (`gen_count`=2), then IDLE.
- Run mode: `run`=1 with `vblank` pulsing → one `buf_swap` per blanking window. Drop `run` mid-sweep → that sweep completes, `gen_count` +1, then IDLE.
- Reset mid-operation: assert `reset` while in ENG_WAIT on row 1 → all outputs 0 asynchronously and no `buf_swap`. A subsequent `get_next` restarts the fetch at row 0.

Source files
------------

// File: rtl/gol_gen_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : gol_gen_scheduler
// Purpose  : Generation scheduler for the Game of Life datapath. Converts
//            single-step requests or continuous run mode into a row-by-row
//            sweep: fetch rows from the current-state buffer, start the
//            engine on each row, swap ping-pong buffers after the last row.
//            A generation only begins during vertical blanking.
// Ports    : clk, reset        - clock, asynchronous active-high reset
//            i_run             - level, repeat generations back-to-back
//            i_get_next        - pulse, request one generation
//            i_vblank          - level, display in vertical blanking
//            o_rd_valid/o_rd_row/i_rd_ready - row-fetch handshake
//            o_eng_start/o_eng_row/o_eng_first/o_eng_last/i_eng_done
//                              - engine row control
//            o_buf_swap        - pulse, swap current/next state buffers
//            o_busy            - high outside IDLE
//            o_gen_count       - completed generations (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module gol_gen_scheduler #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int ROW_AW = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_run,
  input  logic              i_get_next,
  input  logic              i_vblank,
  output logic              o_rd_valid,
  output logic [ROW_AW-1:0] o_rd_row,
  input  logic              i_rd_ready,
  output logic              o_eng_start,
  output logic [ROW_AW-1:0] o_eng_row,
  output logic              o_eng_first,
  output logic              o_eng_last,
  input  logic              i_eng_done,
  output logic              o_buf_swap,
  output logic              o_busy,
  output logic [31:0]       o_gen_count
);

  localparam logic [ROW_AW-1:0] c_last_row = ROW_AW'(HEIGHT - 1);
  localparam logic [ROW_AW-1:0] c_penult   = ROW_AW'(HEIGHT - 2);
  localparam bit c_cfg_ok = (WIDTH > 0) && (HEIGHT >= 2) &&
                            ((64'd1 << ROW_AW) >= 64'(HEIGHT));

  // Elaboration-time guard on the geometry parameters.
  if (!c_cfg_ok) begin : g_cfg_check
    $fatal(1, "gol_gen_scheduler: invalid WIDTH/HEIGHT/ROW_AW");
  end

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_VB  = 3'd1,
    S_FETCH    = 3'd2,
    S_START    = 3'd3,
    S_ENG_WAIT = 3'd4,
    S_SWAP     = 3'd5
  } state_t;

  state_t            r_state;
  logic [ROW_AW-1:0] r_fetch_row;
  logic [ROW_AW-1:0] r_eng_row;
  logic              r_pending;
  logic [31:0]       r_gen_count;

  state_t            w_state;
  logic [ROW_AW-1:0] w_fetch_row;
  logic [ROW_AW-1:0] w_eng_row;
  logic              w_pending;
  logic [31:0]       w_gen_count;
  logic              w_computing;

  // Next-state and next-register computation.
  always_comb begin
    w_state     = r_state;
    w_fetch_row = r_fetch_row;
    w_eng_row   = r_eng_row;
    w_pending   = r_pending;
    w_gen_count = r_gen_count;

    // A request seen while busy is remembered; a second one collapses into it.
    if ((r_state != S_IDLE) && i_get_next) begin
      w_pending = 1'b1;
    end

    case (r_state)
      S_IDLE: begin
        if (i_run || i_get_next) begin
          w_state = S_WAIT_VB;
        end
      end
      S_WAIT_VB: begin
        if (i_vblank) begin
          w_state     = S_FETCH;
          w_fetch_row = '0;
          w_pending   = 1'b0;
        end
      end
      S_FETCH: begin
        // rd_valid is high throughout FETCH, so rd_ready alone is the handshake.
        if (i_rd_ready) begin
          if (r_fetch_row == '0) begin
            // Row 0 only primes the line buffers; row 1 is needed before start.
            w_fetch_row = ROW_AW'(1);
          end else begin
            w_eng_row = r_fetch_row - ROW_AW'(1);
            w_state   = S_START;
          end
        end
      end
      S_START: begin
        w_state = S_ENG_WAIT;
      end
      S_ENG_WAIT: begin
        if (i_eng_done) begin
          if (r_eng_row == c_last_row) begin
            w_state = S_SWAP;
          end else if (r_eng_row == c_penult) begin
            // Bottom halo is dead, so the last row starts without a fetch.
            w_eng_row = c_last_row;
            w_state   = S_START;
          end else begin
            w_fetch_row = r_eng_row + ROW_AW'(2);
            w_state     = S_FETCH;
          end
        end
      end
      S_SWAP: begin
        w_gen_count = r_gen_count + 32'd1;
        // Include a request arriving in this very cycle so it is not lost.
        if (i_run || r_pending || i_get_next) begin
          w_state = S_WAIT_VB;
        end else begin
          w_state = S_IDLE;
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  assign w_computing = (w_state == S_START) || (w_state == S_ENG_WAIT);

  // State, internal registers and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_fetch_row <= '0;
      r_eng_row   <= '0;
      r_pending   <= 1'b0;
      r_gen_count <= '0;
      o_rd_valid  <= 1'b0;
      o_eng_start <= 1'b0;
      o_eng_first <= 1'b0;
      o_eng_last  <= 1'b0;
      o_buf_swap  <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_fetch_row <= w_fetch_row;
      r_eng_row   <= w_eng_row;
      r_pending   <= w_pending;
      r_gen_count <= w_gen_count;
      o_rd_valid  <= (w_state == S_FETCH);
      o_eng_start <= (w_state == S_START);
      o_eng_first <= w_computing && (w_eng_row == '0);
      o_eng_last  <= w_computing && (w_eng_row == c_last_row);
      o_buf_swap  <= (w_state == S_SWAP);
      o_busy      <= (w_state != S_IDLE);
    end
  end

  assign o_rd_row    = r_fetch_row;
  assign o_eng_row   = r_eng_row;
  assign o_gen_count = r_gen_count;

endmodule
`default_nettype wire
